gb_instr_sequencer: RTL and testbench

GB_INSTR_SEQUENCER -- requirements
Module: gb_instr_sequencer

---
 rtl/gbseq_pkg.sv | 28 ++
 rtl/gbseq_lfsr.sv | 29 ++
 rtl/gb_instr_sequencer.sv | 133 +++++++++++++
 tb/tb_gb_instr_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gbseq_pkg.sv
// Shared types and LFSR tap constants for gb_instr_sequencer.
// The LFSR mode itself is only built when GBSEQ_LFSR_EN is defined.
package gbseq_pkg;

  typedef enum logic [1:0] {
    MODE_SWEEP = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;

  // Widths other than 16 fall back to the 8-bit polynomial.
  function automatic logic [15:0] taps_for_width(input int width);
    if (width == 16) return TAPS_16;
    return {8'h00, TAPS_8};
  endfunction

endpackage

// File: rtl/gbseq_lfsr.sv
// Galois right-shift LFSR used for the pseudo-random opcode mode.
// Instantiated by gb_instr_sequencer only when GBSEQ_LFSR_EN is defined.
module gbseq_lfsr
  import gbseq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         advance,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] TAPS = W'(taps_for_width(W));

  // An all-zero state would lock up, so a zero seed is replaced by 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= W'(1);
    end else if (load) begin
      value <= (seed == '0) ? W'(1) : seed;
    end else if (advance) begin
      value <= (value >> 1) ^ (value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/gb_instr_sequencer.sv
// Burst instruction sequencer: sweep, fixed or LFSR opcodes with valid/ready
// handshake and a programmable gap. Define GBSEQ_LFSR_EN to build the LFSR mode.
module gb_instr_sequencer
  import gbseq_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [INSTR_W-1:0] start_value,
  input  logic [CNT_W-1:0]   count,
  input  logic [GAP_W-1:0]   gap,
  input  logic               ready,
  output logic [INSTR_W-1:0] instruction,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   issued
);

`ifdef GBSEQ_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_GAP   = GAP;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]         state;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   count_q;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_cnt;
  mode_e              mode_q;
  mode_e              mode_sel;
  logic               last;

  // Reserved mode acts as fixed; LFSR folds into sweep when not built.
  always_comb begin
    mode_sel = MODE_FIXED;
    case (mode)
      MODE_SWEEP: mode_sel = MODE_SWEEP;
      MODE_LFSR:  mode_sel = LFSR_EN ? MODE_LFSR : MODE_SWEEP;
      default:    mode_sel = MODE_FIXED;
    endcase
  end

  assign last  = (issued + CNT_W'(1)) == count_q;
  assign valid = (state == S_ISSUE);
  assign busy  = (state == S_ISSUE) || (state == S_GAP);
  assign done  = (state == S_DONE);

  // Abort overrides everything and leaves issued untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      instr_q <= '0;
      count_q <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      mode_q  <= MODE_SWEEP;
      issued  <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q  <= mode_sel;
            instr_q <= start_value;
            count_q <= count;
            gap_q   <= gap;
            issued  <= '0;
            state   <= (count == '0) ? S_DONE : S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (ready) begin
            issued <= issued + CNT_W'(1);
            if (last) begin
              state <= S_DONE;
            end else begin
              if (mode_q == MODE_SWEEP) instr_q <= instr_q + INSTR_W'(1);
              if (gap_q != '0) begin
                state   <= S_GAP;
                gap_cnt <= gap_q;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(1)) state <= S_ISSUE;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GBSEQ_LFSR_EN
  logic [INSTR_W-1:0] lfsr_value;
  logic               lfsr_load;
  logic               lfsr_advance;

  assign lfsr_load    = start && !abort && (state == S_IDLE || state == S_DONE)
                        && (mode_sel == MODE_LFSR);
  assign lfsr_advance = valid && ready && !abort && (mode_q == MODE_LFSR);

  gbseq_lfsr #(.W(INSTR_W)) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (lfsr_load),
    .seed    (start_value),
    .advance (lfsr_advance),
    .value   (lfsr_value)
  );

  assign instruction = (mode_q == MODE_LFSR) ? lfsr_value : instr_q;
`else
  assign instruction = instr_q;
`endif

endmodule

// File: tb/tb_gb_instr_sequencer.sv
// Self-checking bench for gb_instr_sequencer: table-driven bursts with a
// scoreboard of expected opcodes plus directed stall/abort/reset sequences.
module tb_gb_instr_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  start_value = 8'h00;
  logic [15:0] count = 16'd0;
  logic [3:0]  gap = 4'd0;
  logic        ready = 1'b0;
  logic [7:0]  instruction;
  logic        valid;
  logic        busy;
  logic        done;
  logic [15:0] issued;

  int n_vec  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0]  m;
    logic [7:0]  sv;
    logic [15:0] cnt;
    logic [3:0]  gp;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  gb_instr_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .start_value (start_value),
    .count       (count),
    .gap         (gap),
    .ready       (ready),
    .instruction (instruction),
    .valid       (valid),
    .busy        (busy),
    .done        (done),
    .issued      (issued)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] model_next(input logic [1:0] m, input logic [7:0] v);
`ifdef GBSEQ_LFSR_EN
    if (m == 2'd2) return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    if (m == 2'd0) return v + 8'd1;
`else
    if (m == 2'd0 || m == 2'd2) return v + 8'd1;
`endif
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] m, input logic [7:0] sv,
                                input logic [15:0] cnt, input logic [3:0] gp);
    logic [7:0] v;
    v = sv;
`ifdef GBSEQ_LFSR_EN
    if (m == 2'd2 && sv == 8'h00) v = 8'h01;
`endif
    for (int i = 0; i < int'(cnt); i++) begin
      exp_q.push_back(v);
      v = model_next(m, v);
    end
    mode = m;
    start_value = sv;
    count = cnt;
    gap = gp;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Each transfer seen mid-cycle pops the next expected opcode.
  always @(negedge clock) begin
    if (reset && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL instr_unexpected: got transfer of %0h, required none", instruction);
      end else begin
        check_output("instr", 32'(instruction), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int lat;

    vecs[0] = '{m: 2'd0, sv: 8'h8C, cnt: 16'd4, gp: 4'd0, exp_lat: 4};
    vecs[1] = '{m: 2'd0, sv: 8'hFE, cnt: 16'd3, gp: 4'd0, exp_lat: 3};
    vecs[2] = '{m: 2'd1, sv: 8'h80, cnt: 16'd2, gp: 4'd2, exp_lat: 4};
    vecs[3] = '{m: 2'd2, sv: 8'h01, cnt: 16'd3, gp: 4'd0, exp_lat: 3};
    vecs[4] = '{m: 2'd2, sv: 8'h00, cnt: 16'd2, gp: 4'd1, exp_lat: 3};
    vecs[5] = '{m: 2'd3, sv: 8'h5A, cnt: 16'd3, gp: 4'd1, exp_lat: 5};
    vecs[6] = '{m: 2'd0, sv: 8'h33, cnt: 16'd0, gp: 4'd0, exp_lat: 0};

    #2 reset = 1'b0;
    #1;
    check_output("reset_instruction", 32'(instruction), 32'h0);
    check_output("reset_valid", 32'(valid), 32'h0);
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_done", 32'(done), 32'h0);
    check_output("reset_issued", 32'(issued), 32'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_output("idle_after_reset_valid", 32'(valid), 32'h0);
    check_output("idle_after_reset_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 7; i++) begin
      ready = 1'b1;
      apply_stimulus(vecs[i].m, vecs[i].sv, vecs[i].cnt, vecs[i].gp);
      check_output("busy_after_start", 32'(busy), 32'(vecs[i].cnt != 16'd0));
      lat = 0;
      while (!done && lat < 100) begin
        @(posedge clock); #1;
        lat++;
      end
      check_output("done_seen", 32'(done), 32'h1);
      check_output("done_latency", 32'(lat), 32'(vecs[i].exp_lat));
      check_output("issued_at_done", 32'(issued), 32'(vecs[i].cnt));
      check_output("valid_at_done", 32'(valid), 32'h0);
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      @(posedge clock); #1;
      check_output("done_one_cycle", 32'(done), 32'h0);
      check_output("busy_after_done", 32'(busy), 32'h0);
    end

    // Consumer stalls the second instruction for three cycles.
    ready = 1'b1;
    apply_stimulus(2'd0, 8'h10, 16'd3, 4'd0);
    @(posedge clock); #1;
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check_output("stall_instruction", 32'(instruction), 32'h11);
      check_output("stall_issued", 32'(issued), 32'h1);
      check_output("stall_valid", 32'(valid), 32'h1);
    end
    ready = 1'b1;
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    check_output("stall_done_seen", 32'(done), 32'h1);
    check_output("stall_issued_final", 32'(issued), 32'h3);
    exp_q.delete();
    @(posedge clock); #1;

    // Abort after two transfers.
    ready = 1'b1;
    apply_stimulus(2'd0, 8'h20, 16'd5, 4'd0);
    repeat (2) begin
      @(posedge clock); #1;
    end
    check_output("pre_abort_issued", 32'(issued), 32'h2);
    abort = 1'b1;
    ready = 1'b0;
    @(posedge clock); #1;
    abort = 1'b0;
    check_output("abort_valid", 32'(valid), 32'h0);
    check_output("abort_busy", 32'(busy), 32'h0);
    check_output("abort_issued", 32'(issued), 32'h2);
    for (int k = 0; k < 3; k++) begin
      check_output("abort_no_done", 32'(done), 32'h0);
      @(posedge clock); #1;
    end
    exp_q.delete();

    // Abort wins over a simultaneous start.
    ready = 1'b1;
    mode = 2'd0;
    count = 16'd3;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    check_output("abort_start_busy", 32'(busy), 32'h0);
    check_output("abort_start_valid", 32'(valid), 32'h0);

    // Reset mid-burst clears outputs without waiting for a clock edge.
    apply_stimulus(2'd0, 8'h40, 16'd10, 4'd0);
    repeat (2) begin
      @(posedge clock); #1;
    end
    reset = 1'b0;
    #1;
    check_output("midreset_instruction", 32'(instruction), 32'h0);
    check_output("midreset_valid", 32'(valid), 32'h0);
    check_output("midreset_busy", 32'(busy), 32'h0);
    check_output("midreset_done", 32'(done), 32'h0);
    check_output("midreset_issued", 32'(issued), 32'h0);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_output("post_reset_valid", 32'(valid), 32'h0);
    check_output("post_reset_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
